sd_cmd_rx: RTL and testbench
============================

Name: sd_cmd_rx

Overview:
Serial receiver for 48-bit SD CMD-line tokens, the receive-side counterpart of the CRC7 generator. It hunts for a start bit after being armed and deserialises the index and argument fields. It computes CRC7 inline over the first 40 bits and compares it with the received CRC field. It reports the decoded fields, CRC/framing status and response timeout to the SD host controller's command FSM.

Parameters:
TIMEOUT, 64, max Enable strobes spent in WAIT_START before Timeout (NCR limit); legal range 2..255
EXP_TX_BIT, 0, required value of frame bit 46 (transmission bit): 0 = card response, 1 = host command (loopback/debug)

Ports:
CLK  input  1  system clock
RST  input  1  reset; asynchronous, active-high
Enable  input  1  bit strobe; CMD_IN is sampled only on CLK edges where Enable=1
CMD_IN  input  1  serial CMD line, MSB first
Start  input  1  one-cycle arm request
Busy  output  1  high in WAIT_START and RECV
Done  output  1  one-cycle pulse at end of frame or timeout
Timeout  output  1  no start bit within TIMEOUT strobes; valid from Done until next Start
CRC_OK  output  1  received CRC7 equals computed CRC7
FRAME_ERR  output  1  end bit != 1 or transmission bit != EXP_TX_BIT
RESP_INDEX  output  6  frame bits 45..40
RESP_ARG  output  32  frame bits 39..8
CRC_RX  output  7  frame bits 7..1 as received

Behaviour:
- Reset (async): state=IDLE; all outputs 0; CRC register, bit counter and timeout counter cleared.
- States: IDLE, WAIT_START, RECV.
- IDLE: Start=1 -> WAIT_START; clear Timeout, CRC_OK, FRAME_ERR, RESP_INDEX, RESP_ARG, CRC_RX; timeout count=0; CRC=0. Start outside IDLE is ignored.
- WAIT_START, on Enable: CMD_IN=0 -> RECV; the start bit is fed to the CRC; bit count=1. CMD_IN=1 -> count++. If that strobe is the TIMEOUT-th strobe without a 0, go to IDLE, set Timeout=1 and pulse Done next cycle. A 0 on the TIMEOUT-th strobe is a start bit, not a timeout.
- RECV, on Enable, bit n (n=1..47, frame bit 47-n):
  - n=1..39: shift into the 39-bit field register and update the CRC.
  - n=40..46: shift into CRC_RX; CRC frozen.
  - n=47: end bit; leave RECV.
- CRC7 update: fb = bit ^ CRC[6]; CRC = {CRC[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00); polynomial x^7+x^3+1, initial value 0.
- Frame completion, on the cycle after the Enable that samples the end bit:
  - Done=1 for exactly one cycle; state=IDLE.
  - RESP_INDEX, RESP_ARG and CRC_RX are valid.
  - CRC_OK = (computed CRC == CRC_RX).
  - FRAME_ERR = (end bit==0) | (bit 46 != EXP_TX_BIT).
- Flags and fields hold until the next accepted Start.
- Enable=0: no state or counter advance; arbitrarily sparse strobes are legal.
- Start coincident with Done: Start is accepted, because the block is already in IDLE when Done is high.
- RST mid-frame: immediate return to IDLE, outputs 0, no Done.
- Busy = (state != IDLE), registered.
- Arithmetic: bit counter is 6 bits; timeout counter is 8 bits and saturates; no wrap is reachable.

Test Plan:
- EXP_TX_BIT=1, Enable every cycle; Start, 3 idle 1s, then 0x40_00000000_95 (CMD0) -> Done 51 cycles after Start; RESP_INDEX=0, RESP_ARG=0, CRC_RX=0x4A, CRC_OK=1, FRAME_ERR=0.
- EXP_TX_BIT=1, Enable every 4th cycle; frame 0x48_000001AA_87 (CMD8) -> RESP_INDEX=8, RESP_ARG=0x000001AA, CRC_RX=0x43, CRC_OK=1.
- Same CMD8 frame with argument bit 0 flipped (0x48_000001AB_87) -> CRC_RX=0x43, CRC_OK=0, FRAME_ERR=0.
- EXP_TX_BIT=0, CMD0 frame -> FRAME_ERR=1. Then CMD55 0x77_00000000_64 (end bit 0) under EXP_TX_BIT=1 -> CRC_RX=0x32, CRC_OK=1, FRAME_ERR=1.
- TIMEOUT=64, CMD_IN held at 1 -> Done and Timeout=1 one cycle after the 64th strobe. Repeat with the 0 on the 64th strobe -> no timeout; the frame is received.
- RST pulsed after 20 frame bits -> outputs 0 and no Done. A new Start plus a clean CMD0 then decodes correctly; Start while Busy leaves the frame unaffected.

Source files
------------

// File: rtl/sd_cmd_rx.sv
// SD CMD-line token receiver: hunts for a start bit, deserialises a 48-bit frame,
// checks CRC7 over the first 40 bits and reports fields, framing status and timeout.
module sd_cmd_rx #(
  parameter int unsigned TIMEOUT    = 64,
  parameter bit          EXP_TX_BIT = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Enable,
  input  logic        CMD_IN,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic        Timeout,
  output logic        CRC_OK,
  output logic        FRAME_ERR,
  output logic [5:0]  RESP_INDEX,
  output logic [31:0] RESP_ARG,
  output logic [6:0]  CRC_RX
);

  localparam logic [8:0] TimeoutLim = 9'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StWaitStart, StRecv} state_e;

  state_e      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic [8:0]  to_inc;
  logic [6:0]  crc_q, crc_d;
  logic [38:0] field_q, field_d;
  logic [6:0]  crc_rx_q, crc_rx_d;
  logic        busy_q, done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        crc_ok_q, crc_ok_d;
  logic        frame_err_q, frame_err_d;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    crc_d       = crc_q;
    field_d     = field_q;
    crc_rx_d    = crc_rx_q;
    done_d      = 1'b0;
    timeout_d   = timeout_q;
    crc_ok_d    = crc_ok_q;
    frame_err_d = frame_err_q;
    to_inc      = {1'b0, to_cnt_q} + 9'd1;

    case (state_q)
      StIdle: begin
        if (Start) begin
          state_d     = StWaitStart;
          bit_cnt_d   = '0;
          to_cnt_d    = '0;
          crc_d       = '0;
          field_d     = '0;
          crc_rx_d    = '0;
          timeout_d   = 1'b0;
          crc_ok_d    = 1'b0;
          frame_err_d = 1'b0;
        end
      end
      StWaitStart: begin
        if (Enable) begin
          if (!CMD_IN) begin
            state_d   = StRecv;
            crc_d     = crc7_step(crc_q, 1'b0);
            bit_cnt_d = 6'd1;
          end else begin
            if (to_cnt_q != 8'hFF) to_cnt_d = to_inc[7:0];
            if (to_inc >= TimeoutLim) begin
              state_d   = StIdle;
              timeout_d = 1'b1;
              done_d    = 1'b1;
            end
          end
        end
      end
      StRecv: begin
        if (Enable) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q <= 6'd39) begin
            // tx bit, index and argument all flow through the CRC
            field_d = {field_q[37:0], CMD_IN};
            crc_d   = crc7_step(crc_q, CMD_IN);
          end else if (bit_cnt_q <= 6'd46) begin
            crc_rx_d = {crc_rx_q[5:0], CMD_IN};
          end else begin
            state_d     = StIdle;
            done_d      = 1'b1;
            crc_ok_d    = (crc_q == crc_rx_q);
            frame_err_d = (!CMD_IN) | (field_q[38] != EXP_TX_BIT);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      crc_q       <= '0;
      field_q     <= '0;
      crc_rx_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      crc_ok_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      crc_q       <= crc_d;
      field_q     <= field_d;
      crc_rx_q    <= crc_rx_d;
      busy_q      <= (state_d != StIdle);
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      crc_ok_q    <= crc_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Timeout    = timeout_q;
  assign CRC_OK     = crc_ok_q;
  assign FRAME_ERR  = frame_err_q;
  assign RESP_INDEX = field_q[37:32];
  assign RESP_ARG   = field_q[31:0];
  assign CRC_RX     = crc_rx_q;

endmodule

// File: tb/tb_sd_cmd_rx.sv
// Randomised bench for sd_cmd_rx: two instances (transmission bit expected 1 and 0)
// share stimulus and are scored against a frame-level reference model.
module tb_sd_cmd_rx;

  localparam int Tmo = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Enable = 1'b0;
  logic        CMD_IN = 1'b1;
  logic        Start = 1'b0;

  logic        busy1, done1, tmo1, ok1, ferr1;
  logic [5:0]  idx1;
  logic [31:0] arg1;
  logic [6:0]  crx1;
  logic        busy0, done0, tmo0, ok0, ferr0;
  logic [5:0]  idx0;
  logic [31:0] arg0;
  logic [6:0]  crx0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt1 = 0;
  int done_cnt0 = 0;
  bit stim[$];

  sd_cmd_rx #(.TIMEOUT(Tmo), .EXP_TX_BIT(1'b1)) u_dut1 (
    .CLK(CLK), .RST(RST), .Enable(Enable), .CMD_IN(CMD_IN), .Start(Start),
    .Busy(busy1), .Done(done1), .Timeout(tmo1), .CRC_OK(ok1), .FRAME_ERR(ferr1),
    .RESP_INDEX(idx1), .RESP_ARG(arg1), .CRC_RX(crx1)
  );

  sd_cmd_rx #(.TIMEOUT(Tmo), .EXP_TX_BIT(1'b0)) u_dut0 (
    .CLK(CLK), .RST(RST), .Enable(Enable), .CMD_IN(CMD_IN), .Start(Start),
    .Busy(busy0), .Done(done0), .Timeout(tmo0), .CRC_OK(ok0), .FRAME_ERR(ferr0),
    .RESP_INDEX(idx0), .RESP_ARG(arg0), .CRC_RX(crx0)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (done1) done_cnt1 <= done_cnt1 + 1;
    if (done0) done_cnt0 <= done_cnt0 + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Remainder of d(x)*x^7 modulo x^7+x^3+1 by long division.
  function automatic logic [6:0] crc7_div(input logic [39:0] d);
    logic [46:0] v;
    v = {d, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) v[i-:8] = v[i-:8] ^ 8'h89;
    end
    return v[6:0];
  endfunction

  task automatic load(input int ones, input logic [47:0] fr);
    stim.delete();
    repeat (ones) stim.push_back(1'b1);
    for (int k = 0; k < 48; k++) stim.push_back(fr[47-k]);
    repeat (4) stim.push_back(1'b1);
  endtask

  task automatic load_ones(input int n);
    stim.delete();
    repeat (n) stim.push_back(1'b1);
  endtask

  task automatic check_outputs(input string p, input bit exp_tx, input bit to,
                               input logic [47:0] fr, input logic busy, input logic done,
                               input logic tmo, input logic ok, input logic ferr,
                               input logic [5:0] idx, input logic [31:0] arg,
                               input logic [6:0] crx);
    logic e_ok, e_ferr;
    e_ok   = to ? 1'b0 : (crc7_div(fr[47:8]) == fr[7:1]);
    e_ferr = to ? 1'b0 : ((!fr[0]) || (fr[46] != exp_tx));
    check_eq({p, "_done"}, 64'(done), 64'(1));
    check_eq({p, "_busy"}, 64'(busy), 64'(0));
    check_eq({p, "_timeout"}, 64'(tmo), 64'(to));
    check_eq({p, "_crc_ok"}, 64'(ok), 64'(e_ok));
    check_eq({p, "_frame_err"}, 64'(ferr), 64'(e_ferr));
    check_eq({p, "_index"}, 64'(idx), to ? 64'(0) : 64'(fr[45:40]));
    check_eq({p, "_arg"}, 64'(arg), to ? 64'(0) : 64'(fr[39:8]));
    check_eq({p, "_crc_rx"}, 64'(crx), to ? 64'(0) : 64'(fr[7:1]));
  endtask

  // Arms the receiver, plays stim one strobe per 'period' cycles up to the model's
  // terminating strobe, then scores both instances.
  task automatic run_seq(input int period, input bit noise);
    int ones, idx, end_i, start_cyc, dc1, dc0;
    bit to;
    logic [47:0] fr;
    ones = 0; idx = -1; to = 1'b0; end_i = 0; fr = '0;
    for (int i = 0; i < stim.size(); i++) begin
      if (stim[i] == 1'b0) begin
        idx = i;
        break;
      end
      ones++;
      if (ones == Tmo) begin
        to = 1'b1;
        end_i = i;
        break;
      end
    end
    if (!to) begin
      if (idx < 0 || idx + 47 >= stim.size()) begin
        $display("FAIL stim_build got=%0d exp=frame", idx);
        $fatal(1, "stimulus too short");
      end
      end_i = idx + 47;
      for (int k = 0; k < 48; k++) fr[47-k] = stim[idx+k];
    end

    Start = 1'b1; Enable = 1'b0;
    @(posedge CLK); #1;
    Start = 1'b0;
    check_eq("arm_done_low", 64'(done1), 64'(0));
    check_eq("arm_busy", 64'(busy1), 64'(1));
    check_eq("arm_timeout_clr", 64'(tmo1), 64'(0));
    check_eq("arm_crc_rx_clr", 64'(crx0), 64'(0));
    start_cyc = cyc; dc1 = done_cnt1; dc0 = done_cnt0;

    for (int i = 0; i <= end_i; i++) begin
      for (int k = 0; k < period; k++) begin
        Enable = (k == period - 1);
        CMD_IN = (k == period - 1) ? stim[i] : 1'($urandom);
        Start  = noise ? 1'($urandom) : 1'b0;
        @(posedge CLK); #1;
      end
    end
    Enable = 1'b0; Start = 1'b0; CMD_IN = 1'b1;

    check_eq("latency", 64'(cyc - start_cyc), 64'((end_i + 1) * period));
    check_eq("early_done1", 64'(done_cnt1 - dc1), 64'(0));
    check_eq("early_done0", 64'(done_cnt0 - dc0), 64'(0));
    check_outputs("d1", 1'b1, to, fr, busy1, done1, tmo1, ok1, ferr1, idx1, arg1, crx1);
    check_outputs("d0", 1'b0, to, fr, busy0, done0, tmo0, ok0, ferr0, idx0, arg0, crx0);
  endtask

  initial begin
    logic [47:0] fr;
    logic [6:0]  c;
    int dc;

    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_busy", 64'(busy1), 64'(0));
    check_eq("rst_done", 64'(done1), 64'(0));
    check_eq("rst_timeout", 64'(tmo1), 64'(0));
    check_eq("rst_crc_ok", 64'(ok1), 64'(0));
    check_eq("rst_frame_err", 64'(ferr0), 64'(0));
    check_eq("rst_fields", 64'({idx1, arg1, crx1}), 64'(0));
    RST = 1'b0;
    @(posedge CLK); #1;

    // CMD0, strobe every cycle
    load(3, 48'h40_00000000_95);
    run_seq(1, 1'b0);
    check_eq("cmd0_crc_rx", 64'(crx1), 64'h4A);
    check_eq("cmd0_crc_ok", 64'(ok1), 64'(1));

    // CMD8, strobe every 4th cycle; then with argument bit 0 flipped
    load(2, 48'h48_000001AA_87);
    run_seq(4, 1'b0);
    check_eq("cmd8_index", 64'(idx1), 64'(8));
    check_eq("cmd8_arg", 64'(arg1), 64'h1AA);
    load(1, 48'h48_000001AB_87);
    run_seq(4, 1'b0);
    check_eq("cmd8_bad_crc_ok", 64'(ok1), 64'(0));
    check_eq("cmd8_bad_crc_rx", 64'(crx1), 64'h43);

    // CMD55 with end bit 0
    load(0, 48'h77_00000000_64);
    run_seq(2, 1'b0);
    check_eq("cmd55_crc_rx", 64'(crx1), 64'h32);
    check_eq("cmd55_frame_err", 64'(ferr1), 64'(1));

    // Timeout at the TIMEOUT-th strobe, then a start bit exactly on that strobe
    load_ones(Tmo + 8);
    run_seq(1, 1'b0);
    load_ones(Tmo + 8);
    run_seq(2, 1'b0);
    load(Tmo - 1, 48'h40_00000000_95);
    run_seq(1, 1'b0);
    check_eq("late_start_no_tmo", 64'(tmo1), 64'(0));

    // Reset in the middle of a frame
    fr = 48'h48_000001AA_87;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    dc = done_cnt1;
    for (int k = 0; k < 20; k++) begin
      Enable = 1'b1; CMD_IN = fr[47-k];
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    #1;
    check_eq("midrst_busy", 64'(busy1), 64'(0));
    check_eq("midrst_fields", 64'({idx1, arg1, crx1, ok1, ferr1, tmo1, done1}), 64'(0));
    check_eq("midrst_busy0", 64'(busy0), 64'(0));
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (60) begin
      Enable = 1'b1; CMD_IN = 1'($urandom);
      @(posedge CLK); #1;
    end
    Enable = 1'b0;
    check_eq("midrst_no_done", 64'(done_cnt1 - dc), 64'(0));
    check_eq("midrst_idle", 64'(busy1), 64'(0));

    // Clean CMD0 with Start toggling while busy
    load(2, 48'h40_00000000_95);
    run_seq(2, 1'b1);

    // Random frames, some with corrupted CRC, bad end bit or long idle preamble
    for (int n = 0; n < 24; n++) begin
      fr[47]    = 1'b0;
      fr[46]    = 1'($urandom);
      fr[45:40] = 6'($urandom);
      fr[39:8]  = $urandom;
      c = crc7_div(fr[47:8]);
      if ($urandom_range(0, 3) == 0) c = c ^ (7'd1 << $urandom_range(0, 6));
      fr[7:1] = c;
      fr[0]   = ($urandom_range(0, 4) != 0);
      if (n % 6 == 5) load($urandom_range(Tmo - 3, Tmo + 2), fr);
      else            load($urandom_range(0, 6), fr);
      run_seq($urandom_range(1, 3), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
